pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controller that drives the program-counter register: computes next-PC each cycle and sequences fetch through IDLE/RUN/HALT.
- Sits between decode/branch-resolution logic and the PC register / instruction memory address port.
- Owns start, halt and stall sequencing, plus a fetched-instruction counter for debug.

Parameters:
BUS_WIDTH, 9, PC/address width in words (instruction memory of 2^BUS_WIDTH words).
RESET_PC, 0, PC value loaded on reset.
CNT_WIDTH, 16, width of fetched-instruction counter.
IMEM_DEPTH, 512, valid instruction words; used only with PC_BOUND_CHECK_EN.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
run  input  1  single-cycle start/resume pulse.
halt_req  input  1  request to stop fetching.
stall  input  1  pipeline stall; hold PC.
jump  input  1  absolute redirect strobe.
jump_target  input  BUS_WIDTH  absolute target word address.
branch_taken  input  1  relative redirect strobe.
branch_offset  input  BUS_WIDTH  two's-complement word offset.
pc  output  BUS_WIDTH  current PC (registered).
fetch_valid  output  1  pc is a live fetch address this cycle.
state  output  2  00 IDLE, 01 RUN, 10 HALT.
fetch_count  output  CNT_WIDTH  number of cycles with fetch_valid=1.
fault  output  1  sticky bound fault (optional feature).

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, state=IDLE, fetch_count=0, fault=0. Because fetch_valid is derived from state, it is 0 during reset.
- fetch_valid = (state==RUN) & ~stall. This is combinational from registered state and the stall input.
- IDLE: pc held. run=1 and halt_req=0 moves to RUN next cycle. Other inputs are ignored.
- RUN: next pc selected by strict priority:
  1. halt_req: go to HALT, pc held.
  2. stall: pc held.
  3. jump: pc <= jump_target.
  4. branch_taken: pc <= pc + 1 + sign_ext(branch_offset).
  5. otherwise: pc <= pc + 1.
- All arithmetic is modulo 2^BUS_WIDTH; carries are dropped, so 0x1FF+1 wraps to 0x000 at the default width.
- jump and branch_taken asserted together: jump wins.
- stall together with jump or branch: the redirect is discarded, not queued. Upstream holds the strobe until stall drops.
- run is ignored in RUN.
- HALT: pc held. run=1 and halt_req=0 moves to RUN, resuming from the held pc. run and halt_req together: remain in HALT.
- fetch_count increments on every rising edge where fetch_valid=1. It saturates at 2^CNT_WIDTH-1 and is cleared only by reset.
- Latency: a redirect strobe sampled at edge N appears on pc after edge N. The first fetch is the cycle after the run pulse.
- Reset asserted mid-operation: immediate return to reset values regardless of state.
- state encoding 11 is unreachable. If entered, the next edge goes to IDLE with pc held.

Optional Feature:
- Macro: PC_BOUND_CHECK_EN.
- With the macro defined, in RUN, if the selected next pc is >= IMEM_DEPTH:
  - pc is not updated;
  - state goes to HALT;
  - fault is set to 1 and is sticky until reset;
  - a run pulse is ignored while fault=1.
- Without the macro, no bound check is made: pc wraps modulo 2^BUS_WIDTH and fault is tied to 0.

Test Plan:
1. Reset, then a run pulse, 4 free cycles -> state 00->01. pc 0,1,2,3,4 on successive fetch cycles. fetch_count=4 after 4 fetch cycles.
2. At pc=0x010: branch_taken with offset 0x1FC (-4) -> pc=0x00D. Next cycle jump+branch_taken with jump_target=0x100 -> pc=0x100 (jump wins).
3. pc=0x1FF with no redirect -> pc=0x000 at the next edge. fault stays 0 with the macro undefined.
4. stall held 3 cycles with jump asserted at pc=0x020 -> pc stays 0x020 and fetch_valid=0 throughout. Jump is dropped. After release, pc=0x021.
5. halt_req at pc=0x030 -> HALT with pc=0x030. run+halt_req together -> stays HALT. run alone -> RUN, next fetch at 0x030.
6. PC_BOUND_CHECK_EN, IMEM_DEPTH=64: jump to 0x040 -> pc unchanged, HALT, fault=1. run pulse ignored. rst_n low mid-cycle -> immediate pc=0, state IDLE, fault=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the control strobes and PC-side outputs of pc_sequencer.
//
// Parameters:
//   BUS_WIDTH  PC / instruction-address width in words
//   CNT_WIDTH  width of the fetched-instruction counter
//
// Signals (direction as seen by the sequencer, i.e. the slave modport):
//   run            in   single-cycle start/resume pulse
//   halt_req       in   request to stop fetching
//   stall          in   pipeline stall, hold PC
//   jump           in   absolute redirect strobe
//   jump_target    in   absolute target word address
//   branch_taken   in   relative redirect strobe
//   branch_offset  in   two's-complement word offset
//   pc             out  current PC (registered)
//   fetch_valid    out  pc is a live fetch address this cycle
//   state          out  00 IDLE, 01 RUN, 10 HALT
//   fetch_count    out  number of cycles with fetch_valid=1 (saturating)
//   fault          out  sticky bound fault
// ----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int unsigned BUS_WIDTH = 9,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 run;
    logic                 halt_req;
    logic                 stall;
    logic                 jump;
    logic [BUS_WIDTH-1:0] jump_target;
    logic                 branch_taken;
    logic [BUS_WIDTH-1:0] branch_offset;
    logic [BUS_WIDTH-1:0] pc;
    logic                 fetch_valid;
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] fetch_count;
    logic                 fault;

    // Upstream control (decode / branch resolution) and PC consumer side.
    modport master (
        output run, halt_req, stall, jump, jump_target, branch_taken, branch_offset,
        input  pc, fetch_valid, state, fetch_count, fault
    );

    // The sequencer itself.
    modport slave (
        input  run, halt_req, stall, jump, jump_target, branch_taken, branch_offset,
        output pc, fetch_valid, state, fetch_count, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Program-counter controller: selects next PC each cycle (halt > stall >
// jump > branch > increment) and sequences fetch through IDLE/RUN/HALT.
// Also keeps a saturating count of fetch cycles for debug.
//
// Optional feature macro: PC_BOUND_CHECK_EN
//   When defined, a RUN-state PC update whose target is >= IMEM_DEPTH is
//   suppressed, the sequencer halts and the sticky fault flag is raised; a run
//   pulse is then ignored until reset. When undefined, fault stays 0 and the
//   PC simply wraps modulo 2^BUS_WIDTH.
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    pc_sequencer_if.slave (control strobes in, pc/status out)
//
// Parameters:
//   BUS_WIDTH   PC width in words
//   RESET_PC    PC value loaded on reset
//   CNT_WIDTH   fetch counter width
//   IMEM_DEPTH  number of valid instruction words (bound check only)
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned BUS_WIDTH  = 9,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned IMEM_DEPTH = 512
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_sequencer_if.slave      bus
);

`ifdef PC_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    state_t               state_q, state_next;
    logic [BUS_WIDTH-1:0] pc_q, pc_next, pc_sel;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 fault_q, fault_next;
    logic                 fetch_live;
    logic                 bound_hit;

    // ------------------------------------------------------------------
    // Candidate next PC for an unstalled RUN cycle. Adding the raw offset
    // modulo 2^BUS_WIDTH is identical to adding its sign extension.
    // ------------------------------------------------------------------
    always_comb begin
        if (bus.jump) begin
            pc_sel = bus.jump_target;
        end else if (bus.branch_taken) begin
            pc_sel = pc_q + BUS_WIDTH'(1) + bus.branch_offset;
        end else begin
            pc_sel = pc_q + BUS_WIDTH'(1);
        end
    end

    // Constant-false when the bound check is not built in.
    assign bound_hit = BOUND_EN && (32'(pc_sel) >= IMEM_DEPTH);

    // ------------------------------------------------------------------
    // State register (plus PC, fault and counter)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= BUS_WIDTH'(RESET_PC);
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_next;
            pc_q    <= pc_next;
            fault_q <= fault_next;
            if (fetch_live && (count_q != '1)) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_q;
        pc_next    = pc_q;
        fault_next = fault_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run && !bus.halt_req) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.halt_req) begin
                    state_next = S_HALT;
                end else if (!bus.stall) begin
                    // A stalled redirect is dropped, not queued.
                    if (bound_hit) begin
                        state_next = S_HALT;
                        fault_next = 1'b1;
                    end else begin
                        pc_next = pc_sel;
                    end
                end
            end
            S_HALT: begin
                if (bus.run && !bus.halt_req && !fault_q) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        fetch_live      = (state_q == S_RUN) && !bus.stall;
        bus.fetch_valid = fetch_live;
        bus.pc          = pc_q;
        bus.state       = state_q;
        bus.fetch_count = count_q;
        bus.fault       = fault_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int unsigned W   = 9;
    localparam int unsigned CW  = 6;
    localparam int unsigned M   = 1 << W;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;
`ifdef PC_BOUND_CHECK_EN
    localparam int unsigned IMEM = 64;
    localparam bit BOUND = 1'b1;
`else
    localparam int unsigned IMEM = 512;
    localparam bit BOUND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer_if #(.BUS_WIDTH(W), .CNT_WIDTH(CW)) bus ();

    pc_sequencer #(
        .BUS_WIDTH (W),
        .RESET_PC  (0),
        .CNT_WIDTH (CW),
        .IMEM_DEPTH(IMEM)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural reference: state as 0 idle / 1 run / 2 halt.
    int m_pc    = 0;
    int m_st    = 0;
    int m_cnt   = 0;
    int m_fault = 0;

    always @(posedge clk or negedge rst_n) begin
        int off;
        int nxt;
        if (!rst_n) begin
            m_pc = 0; m_st = 0; m_cnt = 0; m_fault = 0;
        end else begin
            if (m_st == 1 && !bus.stall && m_cnt < int'(CNT_MAX)) m_cnt = m_cnt + 1;
            if (m_st == 0) begin
                if (bus.run && !bus.halt_req) m_st = 1;
            end else if (m_st == 1) begin
                if (bus.halt_req) begin
                    m_st = 2;
                end else if (!bus.stall) begin
                    off = int'(bus.branch_offset);
                    if (off >= int'(M / 2)) off = off - int'(M);
                    if (bus.jump)              nxt = int'(bus.jump_target);
                    else if (bus.branch_taken) nxt = m_pc + 1 + off;
                    else                       nxt = m_pc + 1;
                    nxt = ((nxt % int'(M)) + int'(M)) % int'(M);
                    if (BOUND && nxt >= int'(IMEM)) begin
                        m_st = 2;
                        m_fault = 1;
                    end else begin
                        m_pc = nxt;
                    end
                end
            end else begin
                if (bus.run && !bus.halt_req && m_fault == 0) m_st = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_pc",    32'(bus.pc),          32'(m_pc));
            chk("cyc_state", 32'(bus.state),       32'(m_st));
            chk("cyc_count", 32'(bus.fetch_count), 32'(m_cnt));
            chk("cyc_fault", 32'(bus.fault),       32'(m_fault));
            chk("cyc_fv",    32'(bus.fetch_valid), 32'((m_st == 1) && !bus.stall));
        end
    end

    task automatic drive(input logic r, input logic h, input logic s, input logic j,
                         input logic [W-1:0] jt, input logic b, input logic [W-1:0] bo);
        bus.run = r; bus.halt_req = h; bus.stall = s; bus.jump = j;
        bus.jump_target = jt; bus.branch_taken = b; bus.branch_offset = bo;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic jump_to(input logic [W-1:0] t);
        drive(1'b0, 1'b0, 1'b0, 1'b1, t, 1'b0, '0);
    endtask

    initial begin
        bus.run = 0; bus.halt_req = 0; bus.stall = 0; bus.jump = 0;
        bus.jump_target = '0; bus.branch_taken = 0; bus.branch_offset = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_pc",    32'(bus.pc), 32'h0);
        chk("rst_state", 32'(bus.state), 32'h0);
        chk("rst_count", 32'(bus.fetch_count), 32'h0);
        chk("rst_fv",    32'(bus.fetch_valid), 32'h0);
        rst_n = 1'b1;

        // Start and free-run.
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("start_state", 32'(bus.state), 32'h1);
        chk("start_pc",    32'(bus.pc), 32'h0);
        for (int i = 0; i < 4; i++) idle_cyc();
        chk("run4_pc",    32'(bus.pc), 32'h4);
        chk("run4_count", 32'(bus.fetch_count), 32'h4);

`ifndef PC_BOUND_CHECK_EN
        // Negative branch, then jump beats branch.
        jump_to(9'h010);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 9'h1FC);
        chk("branch_neg", 32'(bus.pc), 32'h00D);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 9'h100, 1'b1, 9'h1FC);
        chk("jump_wins", 32'(bus.pc), 32'h100);

        // Wrap at top of address space.
        jump_to(9'h1FF);
        idle_cyc();
        chk("wrap_pc",    32'(bus.pc), 32'h000);
        chk("wrap_fault", 32'(bus.fault), 32'h0);
`endif

        // Stall discards a jump.
        jump_to(9'h020);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 9'h055, 1'b0, '0);
            chk("stall_pc", 32'(bus.pc), 32'h020);
            chk("stall_fv", 32'(bus.fetch_valid), 32'h0);
        end
        idle_cyc();
        chk("stall_rel", 32'(bus.pc), 32'h021);

        // Halt and resume.
        jump_to(9'h030);
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("halt_state", 32'(bus.state), 32'h2);
        chk("halt_pc",    32'(bus.pc), 32'h030);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("halt_both",  32'(bus.state), 32'h2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("resume_state", 32'(bus.state), 32'h1);
        chk("resume_pc",    32'(bus.pc), 32'h030);
        chk("resume_fv",    32'(bus.fetch_valid), 32'h1);
        idle_cyc();
        chk("resume_next",  32'(bus.pc), 32'h031);

        // Counter saturation (jump in place keeps pc low).
        for (int i = 0; i < 70; i++) jump_to(9'h000);
        chk("sat_count", 32'(bus.fetch_count), 32'(CNT_MAX));

`ifdef PC_BOUND_CHECK_EN
        jump_to(9'h03F);
        jump_to(9'h040);
        chk("bound_pc",    32'(bus.pc), 32'h03F);
        chk("bound_state", 32'(bus.state), 32'h2);
        chk("bound_fault", 32'(bus.fault), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("bound_run_ign", 32'(bus.state), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pc",    32'(bus.pc), 32'h0);
        chk("async_state", 32'(bus.state), 32'h0);
        chk("async_fault", 32'(bus.fault), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
`endif

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                  W'($urandom_range(0, M - 1)), ($urandom_range(0, 3) == 0),
                  W'($urandom_range(0, M - 1)));
            if ($urandom_range(0, 249) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end

        idle_cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
